counter_ctrl: RTL and testbench

- Upstream control stage for the team's 8-bit up counter. Drives its enable and synchronous clear inputs.
- Provides a programmable prescaler, start/stop/hold control and an optional one-shot terminal count.
- Takes the counter's count back as feedback so it can stop exactly at a programmed limit.
- Sits between the register/control interface and the counter instance.

---
 rtl/counter_ctrl.sv | 141 ++++++++++++++
 tb/tb_counter_ctrl.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/counter_ctrl.sv
// Control stage for an up counter: prescaled enable, start/stop/hold, one-shot stop at limit.
// Optional wrap pulse output when COUNTER_CTRL_WRAP_EN is defined.
module counter_ctrl #(
  parameter int CNT_W = 8,
  parameter int PRE_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             clear,
  input  logic             oneshot,
  input  logic [PRE_W-1:0] prescale,
  input  logic [CNT_W-1:0] limit,
  input  logic [CNT_W-1:0] cnt_in,
  output logic             cnt_en,
  output logic             cnt_rst,
  output logic             busy,
  output logic             done,
`ifdef COUNTER_CTRL_WRAP_EN
  output logic             wrap,
`endif
  output logic [2:0]       dbg_state
);

  // Commands are level inputs with priority clear > stop > start; no handshake.
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ARM  = 3'd1,
    S_RUN  = 3'd2,
    S_HOLD = 3'd3,
    S_CLR  = 3'd4
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [PRE_W-1:0] r_pre_cnt;
  logic [PRE_W-1:0] w_pre_next;
  logic             r_os_q;
  logic             w_os_next;
  logic             r_done;
  logic             w_done_next;
  logic             w_tick;
  logic             w_term;
  logic             w_cnt_en;
  logic             w_cnt_rst;
  logic             w_busy;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_pre_cnt <= '0;
      r_os_q    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_pre_cnt <= w_pre_next;
      r_os_q    <= w_os_next;
      r_done    <= w_done_next;
    end
  end

  always_comb begin
    w_next      = r_state;
    w_pre_next  = r_pre_cnt;
    w_os_next   = r_os_q;
    w_done_next = 1'b0;
    w_cnt_en    = 1'b0;
    w_cnt_rst   = 1'b0;
    w_busy      = 1'b0;
    w_tick      = (r_pre_cnt == '0);
    w_term      = r_os_q && (cnt_in == limit);
    case (r_state)
      S_IDLE: begin
        if (clear) begin
          w_next = S_CLR;
        end else if (start) begin
          w_next    = S_ARM;
          w_os_next = oneshot;
        end
      end
      S_ARM: begin
        w_cnt_rst  = 1'b1;
        w_busy     = 1'b1;
        w_pre_next = prescale;
        w_next     = clear ? S_CLR : S_RUN;
      end
      S_RUN: begin
        w_busy     = 1'b1;
        w_cnt_en   = w_tick && !w_term;
        // Every RUN cycle advances the prescaler, including the one that sees stop.
        w_pre_next = w_tick ? prescale : (r_pre_cnt - {{(PRE_W-1){1'b0}}, 1'b1});
        if (clear) begin
          w_next = S_CLR;
        end else if (w_term) begin
          w_next      = S_IDLE;
          w_done_next = 1'b1;
        end else if (stop) begin
          w_next = S_HOLD;
        end
      end
      S_HOLD: begin
        w_busy = 1'b1;
        if (clear) begin
          w_next = S_CLR;
        end else if (start) begin
          w_next = S_RUN;
        end
      end
      S_CLR: begin
        w_cnt_rst = 1'b1;
        w_next    = clear ? S_CLR : S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Outputs are forced low while reset is asserted, before the state register has cleared.
  assign cnt_en    = w_cnt_en && !reset;
  assign cnt_rst   = w_cnt_rst && !reset;
  assign busy      = w_busy && !reset;
  assign done      = r_done && !reset;
  assign dbg_state = r_state;

`ifdef COUNTER_CTRL_WRAP_EN
  logic r_wrap;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wrap <= 1'b0;
    end else begin
      r_wrap <= w_cnt_en && (cnt_in == {CNT_W{1'b1}});
    end
  end

  assign wrap = r_wrap && !reset;
`endif

endmodule

// File: tb/tb_counter_ctrl.sv
// Bench for counter_ctrl with a behavioural 8-bit counter closing the feedback loop.
`timescale 1ns/1ps
module tb_counter_ctrl;

  logic       clk;
  logic       reset;
  logic       start;
  logic       stop;
  logic       clear;
  logic       oneshot;
  logic [7:0] prescale;
  logic [7:0] limit;
  logic [7:0] cnt;
  logic       cnt_en;
  logic       cnt_rst;
  logic       busy;
  logic       done;
  logic [2:0] dbg_state;
`ifdef COUNTER_CTRL_WRAP_EN
  logic       wrap;
`endif

  int n_checks;
  int n_pass;

  counter_ctrl #(.CNT_W(8), .PRE_W(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .stop      (stop),
    .clear     (clear),
    .oneshot   (oneshot),
    .prescale  (prescale),
    .limit     (limit),
    .cnt_in    (cnt),
    .cnt_en    (cnt_en),
    .cnt_rst   (cnt_rst),
    .busy      (busy),
    .done      (done),
`ifdef COUNTER_CTRL_WRAP_EN
    .wrap      (wrap),
`endif
    .dbg_state (dbg_state)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // the counter being controlled
  always_ff @(posedge clk) begin
    if (reset || cnt_rst) cnt <= 8'd0;
    else if (cnt_en)      cnt <= cnt + 8'd1;
  end

  typedef struct {
    logic       start;
    logic       stop;
    logic       clear;
    logic       oneshot;
    logic [7:0] prescale;
    logic [7:0] limit;
    logic       en;
    logic       rst;
    logic       busy;
    logic       done;
    logic [7:0] cnt;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input logic s, p, c, os, input logic [7:0] pre, lim,
                              input logic en, rst, bz, dn, input logic [7:0] cv);
    vec_t v;
    v.start = s; v.stop = p; v.clear = c; v.oneshot = os;
    v.prescale = pre; v.limit = lim;
    v.en = en; v.rst = rst; v.busy = bz; v.done = dn; v.cnt = cv;
    tbl.push_back(v);
  endfunction

  // scoreboard
  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, got, exp, $time);
  endtask

  task automatic expect_out(input string nm, input logic en, rst, bz, dn, input logic [7:0] cv);
    check({nm, ".cnt_en"},  {31'd0, cnt_en},  {31'd0, en});
    check({nm, ".cnt_rst"}, {31'd0, cnt_rst}, {31'd0, rst});
    check({nm, ".busy"},    {31'd0, busy},    {31'd0, bz});
    check({nm, ".done"},    {31'd0, done},    {31'd0, dn});
    check({nm, ".cnt"},     {24'd0, cnt},     {24'd0, cv});
  endtask

  // driver: apply commands for one cycle, leave time for outputs to settle
  task automatic drive(input logic s, p, c);
    @(negedge clk);
    start = s; stop = p; clear = c;
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    reset = 1'b1; start = 1'b0; stop = 1'b0; clear = 1'b0;
    oneshot = 1'b0; prescale = 8'd0; limit = 8'd0;

    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    expect_out("reset", 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    check("reset.state", {29'd0, dbg_state}, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // one-shot to limit 5 at prescale 0
    add(1,0,0,1, 8'd0, 8'd5, 0,0,0,0, 8'd0);   // IDLE, start accepted
    add(0,0,0,1, 8'd0, 8'd5, 0,1,1,0, 8'd0);   // ARM
    add(0,0,0,1, 8'd0, 8'd5, 1,0,1,0, 8'd0);
    add(0,0,0,1, 8'd0, 8'd5, 1,0,1,0, 8'd1);
    add(0,0,0,1, 8'd0, 8'd5, 1,0,1,0, 8'd2);
    add(0,0,0,1, 8'd0, 8'd5, 1,0,1,0, 8'd3);
    add(0,0,0,1, 8'd0, 8'd5, 1,0,1,0, 8'd4);
    add(0,0,0,1, 8'd0, 8'd5, 0,0,1,0, 8'd5);   // term cycle
    add(0,0,0,1, 8'd0, 8'd5, 0,0,0,1, 8'd5);   // done pulse
    for (int i = 0; i < 10; i++) add(0,0,0,1, 8'd0, 8'd5, 0,0,0,0, 8'd5);
    // zero limit: one RUN cycle, no enables
    add(1,0,0,1, 8'd0, 8'd0, 0,0,0,0, 8'd5);
    add(0,0,0,1, 8'd0, 8'd0, 0,1,1,0, 8'd5);
    add(0,0,0,1, 8'd0, 8'd0, 0,0,1,0, 8'd0);
    add(0,0,0,1, 8'd0, 8'd0, 0,0,0,1, 8'd0);
    add(0,0,0,1, 8'd0, 8'd0, 0,0,0,0, 8'd0);

    foreach (tbl[i]) begin
      @(negedge clk);
      start = tbl[i].start; stop = tbl[i].stop; clear = tbl[i].clear;
      oneshot = tbl[i].oneshot; prescale = tbl[i].prescale; limit = tbl[i].limit;
      #1;
      expect_out($sformatf("vec%0d", i), tbl[i].en, tbl[i].rst, tbl[i].busy, tbl[i].done, tbl[i].cnt);
    end

    // prescaled free-run, then hold/resume, then clear beats start
    oneshot = 1'b0; prescale = 8'd3; limit = 8'd5;
    drive(1, 0, 0); expect_out("fr.idle", 0, 0, 0, 0, 8'd0);
    drive(0, 0, 0); expect_out("fr.arm",  0, 1, 1, 0, 8'd0);
    for (int k = 1; k <= 20; k++) begin
      drive(0, 0, 0);
      expect_out($sformatf("fr.run%0d", k), (k % 4 == 0), 1'b0, 1'b1, 1'b0, 8'((k - 1) / 4));
    end
    drive(0, 1, 0); expect_out("hold.stop", 0, 0, 1, 0, 8'd5);
    for (int k = 0; k < 10; k++) begin
      drive(0, 0, 0);
      expect_out($sformatf("hold.c%0d", k), 0, 0, 1, 0, 8'd5);
      check($sformatf("hold.state%0d", k), {29'd0, dbg_state}, 32'd3);
    end
    drive(1, 0, 0); expect_out("hold.start", 0, 0, 1, 0, 8'd5);
    drive(0, 0, 0); expect_out("resume1", 0, 0, 1, 0, 8'd5);
    drive(0, 0, 0); expect_out("resume2", 0, 0, 1, 0, 8'd5);
    drive(0, 0, 0); expect_out("resume3", 1, 0, 1, 0, 8'd5);
    drive(1, 0, 1); expect_out("clr.req", 0, 0, 1, 0, 8'd6);
    drive(0, 0, 0); expect_out("clr.clr", 0, 1, 0, 0, 8'd6);
    check("clr.state", {29'd0, dbg_state}, 32'd4);
    drive(0, 0, 0); expect_out("clr.idle", 0, 0, 0, 0, 8'd0);

    // reset in the middle of a run
    prescale = 8'd0;
    drive(1, 0, 0);
    drive(0, 0, 0);
    drive(0, 0, 0);
    drive(0, 0, 0); expect_out("rst.run", 1, 0, 1, 0, 8'd1);
    @(negedge clk); reset = 1'b1; #1;
    expect_out("rst.during", 0, 0, 0, 0, 8'd2);
    @(negedge clk); reset = 1'b0; #1;
    expect_out("rst.after", 0, 0, 0, 0, 8'd0);
    check("rst.state", {29'd0, dbg_state}, 32'd0);

`ifdef COUNTER_CTRL_WRAP_EN
    prescale = 8'd0; oneshot = 1'b0;
    drive(1, 0, 0);
    drive(0, 0, 0); check("wrap.arm", {31'd0, wrap}, 32'd0);
    for (int k = 1; k <= 258; k++) begin
      drive(0, 0, 0);
      check($sformatf("wrap.k%0d", k), {31'd0, wrap}, {31'd0, (k == 257)});
      if (k == 257) check("wrap.cnt", {24'd0, cnt}, 32'd0);
    end
    drive(0, 0, 1);
    drive(0, 0, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
